or21nand_bist: RTL

- Built-in self-test stage wrapped around one or21nand cell instance.
- Sits directly upstream of the cell, driving i0/i1/i2, and directly downstream of it, capturing nq.
- Exhaustively applies all 8 input vectors, compares nq against the cell function nq = ~i2 | (~i1 & ~i0), and reports a pass flag, error count and failing-vector bitmap.
- Used on cell characterisation and test-chip rows of the gf180mcu c4m library.

---
 rtl/or21nand_bist_pkg.sv | 7 +
 rtl/or21nand_bist_misr.sv | 21 ++
 rtl/or21nand_bist.sv | 107 ++++++++++
 3 files changed

// File: rtl/or21nand_bist_pkg.sv
// or21nand_bist_pkg: shared FSM states and constants for the or21nand BIST stage.
package or21nand_bist_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    localparam logic [7:0]  EXP_MASK  = 8'h1F;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;
endpackage

// File: rtl/or21nand_bist_misr.sv
// or21nand_bist_misr: 16-bit MISR (x^16+x^12+x^5+1), LSB-first insertion, synchronous seed load.
module or21nand_bist_misr
    import or21nand_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        en_i,
    input  logic        din_i,
    output logic [15:0] sig_o
);
    logic [15:0] sig_q, sig_d;
    assign sig_d = load_i ? MISR_SEED
                 : en_i   ? ({sig_q[14:0], din_i} ^ (sig_q[15] ? MISR_POLY : 16'h0000))
                 : sig_q;
    always_ff @(posedge clk) begin
        if (rst) sig_q <= MISR_SEED;
        else     sig_q <= sig_d;
    end
    assign sig_o = sig_q;
endmodule

// File: rtl/or21nand_bist.sv
// or21nand_bist: exhaustive 8-vector BIST around one or21nand cell.
// Define OR21NAND_BIST_SIGNATURE_EN to add the 16-bit MISR signature output sig.
module or21nand_bist
    import or21nand_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_i0,
    output logic             dut_i1,
    output logic             dut_i2,
    input  logic             dut_nq,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       fail_vec
`ifdef OR21NAND_BIST_SIGNATURE_EN
    ,
    output logic [15:0]      sig
`endif
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0]    S_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]    P_LAST = PW'(PASSES - 1);
    localparam logic [CNT_W-1:0] E_MAX  = '1;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [PW-1:0]    pidx_q, pidx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [7:0]       fail_q, fail_d;
    logic             accept, check, mism;

    // start is honoured only when not busy; rst takes priority in the register block
    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign check  = state_q == CHECK;
    assign mism   = check && (dut_nq != EXP_MASK[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        scnt_d  = scnt_q;
        pidx_d  = pidx_q;
        err_d   = err_q;
        fail_d  = fail_q;
        if (accept) begin
            state_d = SETTLE;
            vec_d   = '0;
            scnt_d  = '0;
            pidx_d  = '0;
            err_d   = '0;
            fail_d  = '0;
        end else if (state_q == SETTLE) begin
            state_d = scnt_q == S_LAST ? CHECK : SETTLE;
            scnt_d  = scnt_q == S_LAST ? '0 : scnt_q + 1'b1;
        end else if (check) begin
            vec_d   = vec_q + 3'd1;
            pidx_d  = vec_q == 3'd7 ? pidx_q + 1'b1 : pidx_q;
            state_d = (vec_q == 3'd7 && pidx_q == P_LAST) ? DONE : SETTLE;
            err_d   = (mism && err_q != E_MAX) ? err_q + 1'b1 : err_q;
            if (mism) fail_d[vec_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            scnt_q  <= '0;
            pidx_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            scnt_q  <= scnt_d;
            pidx_q  <= pidx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign {dut_i2, dut_i1, dut_i0} = vec_q;
    assign busy     = state_q == SETTLE || state_q == CHECK;
    assign done     = state_q == DONE;
    assign pass     = done && err_q == '0;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

`ifdef OR21NAND_BIST_SIGNATURE_EN
    or21nand_bist_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .en_i   (check),
        .din_i  (dut_nq),
        .sig_o  (sig)
    );
`endif
endmodule
